// File: rtl/alu_pkg.sv
// ALU op-code definitions and the reference result function shared by the
// ALU, the result checker and the benches.
`timescale 1ns/1ps
package alu_pkg;

    localparam int ALU_OP_W  = 3;
    localparam int ALU_MAX_W = 64;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd4;

    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        return (op <= ALU_XOR);
    endfunction

    // Computed at the widest supported width; callers truncate. Low bits of a
    // sum or difference do not depend on the high bits, so truncation is exact.
    function automatic logic [ALU_MAX_W-1:0] alu_expected(
        input logic [ALU_OP_W-1:0]  op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b
    );
        logic [ALU_MAX_W-1:0] res;
        res = '0;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers for full/empty distinction and
// a combinational head output.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    // Full blocks a push even when a pop happens in the same cycle.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    assign dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_result_checker.sv
// Receives ALU transactions through a small FIFO, recomputes each result and
// keeps pass/fail/illegal statistics plus a capture of the first mismatch.
`timescale 1ns/1ps
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    input  logic [DATA_W-1:0]   in_result,
    output logic [CNT_W-1:0]    pass_count,
    output logic [CNT_W-1:0]    fail_count,
    output logic [CNT_W-1:0]    illegal_count,
    output logic                fail_seen,
    output logic [ALU_OP_W-1:0] fail_op,
    output logic [DATA_W-1:0]   fail_a,
    output logic [DATA_W-1:0]   fail_b,
    output logic [DATA_W-1:0]   fail_got,
    output logic [DATA_W-1:0]   fail_exp,
    output logic                idle
);

    localparam int FW = ALU_OP_W + 3 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [FW-1:0]       w_fifo_din;
    logic [FW-1:0]       w_fifo_dout;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic [ALU_OP_W-1:0] w_head_op;
    logic [DATA_W-1:0]   w_head_a;
    logic [DATA_W-1:0]   w_head_b;
    logic [DATA_W-1:0]   w_head_got;

    logic                r_cmp_valid;
    logic [ALU_OP_W-1:0] r_cmp_op;
    logic [DATA_W-1:0]   r_cmp_a;
    logic [DATA_W-1:0]   r_cmp_b;
    logic [DATA_W-1:0]   r_cmp_got;
    logic [DATA_W-1:0]   w_exp;
    logic                w_legal;
    logic                w_match;

    logic [CNT_W-1:0]    r_pass_count;
    logic [CNT_W-1:0]    r_fail_count;
    logic [CNT_W-1:0]    r_illegal_count;
    logic                r_fail_seen;
    logic [ALU_OP_W-1:0] r_fail_op;
    logic [DATA_W-1:0]   r_fail_a;
    logic [DATA_W-1:0]   r_fail_b;
    logic [DATA_W-1:0]   r_fail_got;
    logic [DATA_W-1:0]   r_fail_exp;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    assign w_fifo_din = {in_op, in_a, in_b, in_result};
    assign {w_head_op, w_head_a, w_head_b, w_head_got} = w_fifo_dout;
    // The compare register drains every cycle, so a pop is always possible.
    assign w_pop = !w_empty;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign in_ready = !w_full;
    assign idle     = w_empty && !r_cmp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_valid <= 1'b0;
            r_cmp_op    <= '0;
            r_cmp_a     <= '0;
            r_cmp_b     <= '0;
            r_cmp_got   <= '0;
        end else begin
            r_cmp_valid <= w_pop;
            if (w_pop) begin
                r_cmp_op  <= w_head_op;
                r_cmp_a   <= w_head_a;
                r_cmp_b   <= w_head_b;
                r_cmp_got <= w_head_got;
            end
        end
    end

    assign w_exp   = DATA_W'(alu_expected(r_cmp_op, ALU_MAX_W'(r_cmp_a), ALU_MAX_W'(r_cmp_b)));
    assign w_legal = alu_op_legal(r_cmp_op);
    assign w_match = (w_exp == r_cmp_got);

    // clear has priority over the compare result of the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_count    <= '0;
            r_fail_count    <= '0;
            r_illegal_count <= '0;
            r_fail_seen     <= 1'b0;
            r_fail_op       <= '0;
            r_fail_a        <= '0;
            r_fail_b        <= '0;
            r_fail_got      <= '0;
            r_fail_exp      <= '0;
        end else if (clear) begin
            r_pass_count    <= '0;
            r_fail_count    <= '0;
            r_illegal_count <= '0;
            r_fail_seen     <= 1'b0;
            r_fail_op       <= '0;
            r_fail_a        <= '0;
            r_fail_b        <= '0;
            r_fail_got      <= '0;
            r_fail_exp      <= '0;
        end else if (r_cmp_valid) begin
            if (!w_legal) begin
                r_illegal_count <= sat_inc(r_illegal_count);
            end else if (w_match) begin
                r_pass_count <= sat_inc(r_pass_count);
            end else begin
                r_fail_count <= sat_inc(r_fail_count);
                if (!r_fail_seen) begin
                    r_fail_seen <= 1'b1;
                    r_fail_op   <= r_cmp_op;
                    r_fail_a    <= r_cmp_a;
                    r_fail_b    <= r_cmp_b;
                    r_fail_got  <= r_cmp_got;
                    r_fail_exp  <= w_exp;
                end
            end
        end
    end

    assign pass_count    = r_pass_count;
    assign fail_count    = r_fail_count;
    assign illegal_count = r_illegal_count;
    assign fail_seen     = r_fail_seen;
    assign fail_op       = r_fail_op;
    assign fail_a        = r_fail_a;
    assign fail_b        = r_fail_b;
    assign fail_got      = r_fail_got;
    assign fail_exp      = r_fail_exp;

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: directed scenarios followed by
// random traffic, checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_result_checker;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_result;
    logic [15:0] pass_count;
    logic [15:0] fail_count;
    logic [15:0] illegal_count;
    logic        fail_seen;
    logic [2:0]  fail_op;
    logic [31:0] fail_a;
    logic [31:0] fail_b;
    logic [31:0] fail_got;
    logic [31:0] fail_exp;
    logic        idle;

    alu_result_checker #(
        .DATA_W (32),
        .DEPTH  (4),
        .CNT_W  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_result     (in_result),
        .pass_count    (pass_count),
        .fail_count    (fail_count),
        .illegal_count (illegal_count),
        .fail_seen     (fail_seen),
        .fail_op       (fail_op),
        .fail_a        (fail_a),
        .fail_b        (fail_b),
        .fail_got      (fail_got),
        .fail_exp      (fail_exp),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          acc;
        int          due;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] got;
        logic [31:0] exp;
        int          kind;  // 0 match, 1 miss, 2 illegal
    } item_t;

    item_t sb_q[$];
    bit    clr_map[int];

    int          checks = 0;
    int          errors = 0;
    int          m_pass = 0;
    int          m_fail = 0;
    int          m_ill  = 0;
    logic        m_fseen = 1'b0;
    logic [2:0]  m_fop   = '0;
    logic [31:0] m_fa    = '0;
    logic [31:0] m_fb    = '0;
    logic [31:0] m_fgot  = '0;
    logic [31:0] m_fexp  = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_zero();
        m_pass = 0; m_fail = 0; m_ill = 0;
        m_fseen = 1'b0; m_fop = '0; m_fa = '0; m_fb = '0; m_fgot = '0; m_fexp = '0;
    endtask

    // Monitor: retires scoreboard entries when their result is due and
    // compares every observable output against the model each cycle.
    initial begin
        item_t it;
        bit    busy;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (clr_map.exists(cyc)) model_zero();
                while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    it = sb_q.pop_front();
                    if (clr_map.exists(it.due)) begin
                        $display("txn acc=%0d op=%0d dropped by clear", it.acc, it.op);
                        continue;
                    end
                    $display("txn acc=%0d op=%0d a=%h b=%h got=%h exp=%h kind=%0d",
                             it.acc, it.op, it.a, it.b, it.got, it.exp, it.kind);
                    if (it.kind == 2) m_ill = sat(m_ill);
                    else if (it.kind == 0) m_pass = sat(m_pass);
                    else begin
                        m_fail = sat(m_fail);
                        if (!m_fseen) begin
                            m_fseen = 1'b1; m_fop = it.op; m_fa = it.a; m_fb = it.b;
                            m_fgot = it.got; m_fexp = it.exp;
                        end
                    end
                end
                busy = 1'b0;
                foreach (sb_q[i]) if (sb_q[i].acc <= cyc) busy = 1'b1;
                chk("pass_count",    64'(pass_count),    64'(m_pass));
                chk("fail_count",    64'(fail_count),    64'(m_fail));
                chk("illegal_count", 64'(illegal_count), 64'(m_ill));
                chk("fail_seen",     64'(fail_seen),     64'(m_fseen));
                chk("fail_op",       64'(fail_op),       64'(m_fop));
                chk("fail_a",        64'(fail_a),        64'(m_fa));
                chk("fail_b",        64'(fail_b),        64'(m_fb));
                chk("fail_got",      64'(fail_got),      64'(m_fgot));
                chk("fail_exp",      64'(fail_exp),      64'(m_fexp));
                chk("idle",          64'(idle),          64'(!busy));
                chk("in_ready",      64'(in_ready),      64'd1);
            end
        end
    end

    // Called at a negedge; the transfer happens at the following rising edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input bit clr);
        item_t it;
        int    tries = 0;
        in_op = op; in_a = a; in_b = b; in_result = r;
        in_valid = 1'b1;
        clear = clr;
        while (!in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) chk("in_ready_wait", 64'(in_ready), 64'd1);
        if (clr) clr_map[cyc + 1] = 1'b1;
        it.acc = cyc + 1;
        it.due = cyc + 3;
        it.op = op; it.a = a; it.b = b; it.got = r;
        it.exp = ref_result(op, a, b);
        it.kind = (op > 3'd4) ? 2 : ((r == it.exp) ? 0 : 1);
        if (in_ready) sb_q.push_back(it);
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        clr_map[cyc + 1] = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int          e0;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_result = '0;
        repeat (2) @(negedge clk);
        chk("rst_pass",     64'(pass_count), 64'd0);
        chk("rst_idle",     64'(idle),       64'd1);
        chk("rst_in_ready", 64'(in_ready),   64'd1);
        chk("rst_fail_exp", 64'(fail_exp),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(3'd0, 32'd5, 32'd7, 32'd12, 1'b0);
        drain();
        chk("add_pass", 64'(pass_count), 64'd1);
        chk("add_idle", 64'(idle),       64'd1);

        do_clear();
        send(3'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        send(3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
        drain();
        chk("subxor_pass", 64'(pass_count), 64'd2);
        chk("subxor_fail", 64'(fail_count), 64'd0);

        do_clear();
        send(3'd2, 32'hFF, 32'h0F, 32'hFF, 1'b0);
        send(3'd3, 32'd1, 32'd2, 32'd0, 1'b0);
        drain();
        chk("andor_fail",     64'(fail_count), 64'd2);
        chk("andor_seen",     64'(fail_seen),  64'd1);
        chk("andor_fail_op",  64'(fail_op),    64'd2);
        chk("andor_fail_a",   64'(fail_a),     64'hFF);
        chk("andor_fail_b",   64'(fail_b),     64'h0F);
        chk("andor_fail_got", 64'(fail_got),   64'hFF);
        chk("andor_fail_exp", 64'(fail_exp),   64'h0F);

        send(3'd5, $urandom, $urandom, $urandom, 1'b0);
        send(3'd6, $urandom, $urandom, $urandom, 1'b0);
        send(3'd7, $urandom, $urandom, $urandom, 1'b0);
        drain();
        chk("illegal_count", 64'(illegal_count), 64'd3);
        chk("illegal_pass",  64'(pass_count),    64'd0);
        chk("illegal_fail",  64'(fail_count),    64'd2);

        do_clear();
        e0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom;
            send(3'd0, a, b, a + b, 1'b0);
        end
        in_valid = 1'b0;
        while (cyc < e0 + 12) @(negedge clk);
        chk("burst_pass", 64'(pass_count), 64'd10);

        drain();
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            send(3'd0, a, b, a + b, i == 3);
        end
        drain();
        chk("clear_mid_pass", 64'(pass_count), 64'd4);

        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            send(3'd1, a, b, a - b, 1'b0);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pass",  64'(pass_count), 64'd0);
        chk("async_rst_idle",  64'(idle),       64'd1);
        chk("async_rst_ready", 64'(in_ready),   64'd1);
        sb_q.delete();
        model_zero();
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_pass", 64'(pass_count), 64'd0);
        chk("post_rst_idle", 64'(idle),       64'd1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                op = 3'($urandom_range(0, 7));
                a = $urandom; b = $urandom;
                r = ($urandom_range(0, 9) < 7) ? ref_result(op, a, b) : $urandom;
                send(op, a, b, r, $urandom_range(0, 39) == 0);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
